// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: valid/ready request and response channels,
// fixed access latency, alignment/range/bounds checking and an internal storage array.
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_chk,
    input  logic [31:0] req_limit,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_we
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        chk_q, chk_d;
    logic [31:0] limit_q, limit_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        resp_we_q, resp_we_d;

    logic [31:0]     mem [DEPTH];
    logic [IdxW-1:0] idx;
    logic            access_err;
    logic            mem_wr;

    // Only the low index bits address the array; the full word address feeds the range check.
    assign idx        = addr_q[IdxW+1:2];
    assign access_err = (addr_q[1:0] != 2'b00)
                      | ({2'b00, addr_q[31:2]} >= 32'(DEPTH))
                      | (chk_q & (addr_q >= limit_q));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        chk_d        = chk_q;
        limit_d      = limit_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_we_d    = resp_we_q;
        mem_wr       = 1'b0;
        req_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    chk_d   = req_chk;
                    limit_d = req_limit;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    err_d        = access_err;
                    resp_we_d    = we_q;
                    rdata_d      = (!access_err && !we_q) ? mem[idx] : 32'h0;
                    mem_wr       = we_q & ~access_err;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A store whose commit edge coincides with reset is aborted.
        if (reset) begin
            req_ready = 1'b0;
            mem_wr    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            chk_q        <= 1'b0;
            limit_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            chk_q        <= chk_d;
            limit_q      <= limit_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign resp_we    = resp_we_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; three instances cover LATENCY 2, 1 and 15.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        rv   [3];
    logic        rr   [3];
    logic        rdy  [3];
    logic        rvld [3];
    logic        rerr [3];
    logic        rwe  [3];
    logic [31:0] rdata[3];
    logic        we;
    logic        chk;
    logic [31:0] addr, wdata, limit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut_l2 (
        .clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_chk(chk), .req_limit(limit),
        .resp_valid(rvld[0]), .resp_ready(rr[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]),
        .resp_we(rwe[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_chk(chk), .req_limit(limit),
        .resp_valid(rvld[1]), .resp_ready(rr[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]),
        .resp_we(rwe[1])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(15)) u_dut_l15 (
        .clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_chk(chk), .req_limit(limit),
        .resp_valid(rvld[2]), .resp_ready(rr[2]), .resp_rdata(rdata[2]), .resp_err(rerr[2]),
        .resp_we(rwe[2])
    );

    // One transaction with resp_ready=1. Reports latency (edges from acceptance to resp_valid)
    // and the number of cycles req_ready stayed low after acceptance.
    task automatic txn(input int sel, input logic twe, input logic [31:0] taddr,
                       input logic [31:0] twdata, input logic tchk, input logic [31:0] tlimit,
                       output logic [31:0] o_rdata, output logic o_err, output logic o_we,
                       output int o_lat, output int o_low);
        int waitn;
        rr[sel] = 1'b1;
        @(negedge clock);
        we = twe; addr = taddr; wdata = twdata; chk = tchk; limit = tlimit;
        rv[sel] = 1'b1;
        waitn = 0;
        while (!rdy[sel] && waitn < 50) begin
            @(negedge clock);
            waitn++;
        end
        if (!rdy[sel]) begin
            n_checks++; n_fail++;
            $display("FAIL txn_accept sel=%0d: req_ready=0, required 1", sel);
        end
        @(posedge clock);
        #1;
        rv[sel] = 1'b0;
        // Scramble inputs after acceptance; they must not affect the transaction.
        we = ~twe; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; chk = ~tchk; limit = 32'h0;
        o_lat = -1; o_low = 0; o_rdata = 32'h0; o_err = 1'b0; o_we = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rvld[sel] && o_lat < 0) begin
                o_lat   = i;
                o_rdata = rdata[sel];
                o_err   = rerr[sel];
                o_we    = rwe[sel];
            end
            if (rdy[sel]) break;
            o_low++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin rv[i] = 1'b0; rr[i] = 1'b1; end
        we = 1'b0; addr = 32'h0; wdata = 32'h0; chk = 1'b0; limit = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({rdy[0], rvld[0], rdata[0], rerr[0], rwe[0]} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b we=%b, required all 0",
                     rdy[0], rvld[0], rdata[0], rerr[0], rwe[0]);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", rdy[0]);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] d; logic e, w; int lat, low;
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e, w} !== {32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL store_resp: got rdata=%h err=%b we=%b, required 0/0/1", d, e, w);
        end
        n_checks++;
        if (lat !== 2 || low !== 3) begin
            n_fail++;
            $display("FAIL store_timing: got lat=%0d low=%0d, required 2/3", lat, low);
        end
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e, w} !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_resp: got rdata=%h err=%b we=%b, required deadbeef/0/0", d, e, w);
        end
        n_checks++;
        if (lat !== 2 || low !== 3) begin
            n_fail++;
            $display("FAIL load_timing: got lat=%0d low=%0d, required 2/3", lat, low);
        end
    endtask

    task automatic test_backpressure();
        int k;
        rr[0] = 1'b0;
        @(negedge clock);
        we = 1'b0; addr = 32'h10; chk = 1'b0; rv[0] = 1'b1;
        @(posedge clock);
        #1;
        rv[0] = 1'b0;
        k = 0;
        while (!rvld[0] && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({rvld[0], rdy[0], rerr[0], rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL backpressure_hold c=%0d: got vld=%b rdy=%b err=%b rdata=%h, required 1/0/0/deadbeef",
                         c, rvld[0], rdy[0], rerr[0], rdata[0]);
            end
            if (c < 4) begin
                @(posedge clock);
                #1;
            end
        end
        @(negedge clock);
        rr[0] = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({rvld[0], rdy[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, required 0/1", rvld[0], rdy[0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e, w; int lat, low;
        txn(0, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL misaligned_load: got rdata=%h err=%b, required 0/1", d, e);
        end
        txn(0, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL range_load: got rdata=%h err=%b, required 0/1", d, e);
        end
        txn(0, 1'b1, 32'h4, 32'h1111_1111, 1'b0, 32'h0, d, e, w, lat, low);
        txn(0, 1'b1, 32'h1004, 32'h2222_2222, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e, w} !== {32'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL range_store: got rdata=%h err=%b we=%b, required 0/1/1", d, e, w);
        end
        txn(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h1111_1111, 1'b0}) begin
            n_fail++;
            $display("FAIL range_store_readback: got rdata=%h err=%b, required 11111111/0", d, e);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] d; logic e, w; int lat, low;
        txn(0, 1'b1, 32'h20, 32'h55, 1'b0, 32'h0, d, e, w, lat, low);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h40, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL bound_inside: got rdata=%h err=%b, required 55/0", d, e);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b1, 32'h20, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL bound_at_limit: got rdata=%h err=%b, required 0/1", d, e);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL bound_unchecked: got rdata=%h err=%b, required 55/0", d, e);
        end
        txn(0, 1'b1, 32'h20, 32'h99, 1'b1, 32'h10, d, e, w, lat, low);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL bound_store_dropped: got rdata=%h err=%b, required 55/0", d, e);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] d; logic e, w; int lat, low;
        txn(0, 1'b1, 32'h8, 32'h1, 1'b0, 32'h0, d, e, w, lat, low);
        @(negedge clock);
        we = 1'b1; addr = 32'h8; wdata = 32'hA5A5_A5A5; chk = 1'b0; rv[0] = 1'b1;
        @(posedge clock);
        #1;
        rv[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({rvld[0], rdy[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got vld=%b rdy=%b, required 0/0", rvld[0], rdy[0]);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rvld[0], rdy[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got vld=%b rdy=%b, required 0/1", rvld[0], rdy[0]);
        end
        txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
        n_checks++;
        if ({d, e} !== {32'h1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_readback: got rdata=%h err=%b, required 1/0", d, e);
        end
    endtask

    task automatic test_latency_sweep();
        logic [31:0] d; logic e, w; int lat, low;
        int lats[3];
        lats[0] = 2; lats[1] = 1; lats[2] = 15;
        for (int s = 1; s < 3; s++) begin
            txn(s, 1'b1, 32'h40, 32'hC0FF_EE00 + s, 1'b0, 32'h0, d, e, w, lat, low);
            n_checks++;
            if (lat !== lats[s] || low !== lats[s] + 1 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_store L=%0d: got lat=%0d low=%0d err=%b, required %0d/%0d/0",
                         lats[s], lat, low, e, lats[s], lats[s] + 1);
            end
            txn(s, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, d, e, w, lat, low);
            n_checks++;
            if (lat !== lats[s] || low !== lats[s] + 1 || d !== 32'hC0FF_EE00 + s) begin
                n_fail++;
                $display("FAIL sweep_load L=%0d: got lat=%0d low=%0d rdata=%h, required %0d/%0d/%h",
                         lats[s], lat, low, d, lats[s], lats[s] + 1, 32'hC0FF_EE00 + s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_backpressure();
        test_errors();
        test_bounds();
        test_reset_mid_store();
        test_latency_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
